// File: rtl/user_au_pkg.sv
// rtl/user_au_pkg.sv - shared types and constants for the OBI audio sample fetcher
package user_au_pkg;

  localparam int AddrWidth   = 32;
  localparam int DataWidth   = 32;
  localparam int SampleBytes = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    STOPPING
  } fetcher_state_e;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [0:0]             aid;
    logic                   a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

// File: rtl/user_au_sample_fifo.sv
// rtl/user_au_sample_fifo.sv - synchronous sample FIFO with flush and occupancy count
module user_au_sample_fifo #(
  parameter int Depth = 4,
  parameter int Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_full, w_push_ok, w_pop_ok;

  assign empty_o   = (r_count == '0);
  assign w_full    = (r_count == CntW'(Depth));
  assign w_pop_ok  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = push_i && (!w_full || pop_i);
  assign data_o    = empty_o ? '0 : r_mem[r_rd_ptr];
  assign count_o   = r_count;

  always_ff @(posedge clk_i) begin
    if (w_push_ok && !flush_i) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/user_au_obi_sample_fetcher.sv
// rtl/user_au_obi_sample_fetcher.sv - OBI manager streaming 32-bit samples from a memory buffer
module user_au_obi_sample_fetcher
  import user_au_pkg::*;
#(
  parameter int FifoDepth = 4,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output obi_req_t             obi_req_o,
  input  obi_rsp_t             obi_rsp_i,
  input  logic                 cfg_start_i,
  input  logic                 cfg_stop_i,
  input  logic                 cfg_loop_i,
  input  logic [AddrWidth-1:0] cfg_base_addr_i,
  input  logic [CntWidth-1:0]  cfg_num_samples_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [31:0]          data_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int CntW = $clog2(FifoDepth) + 1;

  fetcher_state_e       r_state, w_state_n;
  logic [AddrWidth-1:0] r_addr, r_base, w_base;
  logic [CntWidth-1:0]  r_remaining, r_num;
  logic                 r_loop, r_err, r_done;
  logic                 w_req, w_push, w_flush, w_pop, w_empty;
  logic                 w_start_ok, w_zero_start, w_beat, w_err_set, w_drain_done;
  logic [CntW-1:0]      w_count;
  logic [31:0]          w_push_data;

  assign w_base      = cfg_base_addr_i & ~AddrWidth'(SampleBytes - 1);
  assign w_push_data = obi_rsp_i.r.err ? '0 : obi_rsp_i.r.rdata;
  assign w_pop       = !w_empty && ready_i;
  assign valid_o     = !w_empty;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;

  always_comb begin
    obi_req_o          = '0;
    obi_req_o.a.addr   = r_addr;
    obi_req_o.a.be     = '1;
    obi_req_o.req      = w_req;
    obi_req_o.rready   = 1'b1;
  end

  always_comb begin
    w_state_n    = r_state;
    w_req        = 1'b0;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    w_start_ok   = 1'b0;
    w_zero_start = 1'b0;
    w_beat       = 1'b0;
    w_err_set    = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_start_i) begin
          if (cfg_num_samples_i == '0) begin
            w_zero_start = 1'b1;
          end else begin
            w_start_ok = 1'b1;
            w_state_n  = REQ;
          end
        end
      end
      REQ: begin
        // Only one transaction is ever in flight, so a free slot now stays free until its response.
        w_req = (w_count < CntW'(FifoDepth));
        if (cfg_stop_i) begin
          w_flush   = 1'b1;
          w_state_n = (w_req && obi_rsp_i.gnt) ? STOPPING : IDLE;
        end else if (w_req && obi_rsp_i.gnt) begin
          w_state_n = WAIT;
        end
      end
      WAIT: begin
        if (cfg_stop_i) begin
          w_flush   = 1'b1;
          w_state_n = obi_rsp_i.rvalid ? IDLE : STOPPING;
        end else if (obi_rsp_i.rvalid) begin
          w_push    = 1'b1;
          w_beat    = 1'b1;
          w_err_set = obi_rsp_i.r.err;
          if (r_remaining == CntWidth'(1)) w_state_n = r_loop ? REQ : DRAIN;
          else                             w_state_n = REQ;
        end
      end
      DRAIN: begin
        if (cfg_stop_i) begin
          w_flush   = 1'b1;
          w_state_n = IDLE;
        end else if (w_empty) begin
          w_drain_done = 1'b1;
          w_state_n    = IDLE;
        end
      end
      STOPPING: begin
        w_flush = cfg_stop_i;
        if (obi_rsp_i.rvalid) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_base      <= '0;
      r_remaining <= '0;
      r_num       <= '0;
      r_loop      <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_done  <= w_zero_start || w_drain_done;
      if (w_start_ok) begin
        r_base      <= w_base;
        r_addr      <= w_base;
        r_remaining <= cfg_num_samples_i;
        r_num       <= cfg_num_samples_i;
        r_loop      <= cfg_loop_i;
        r_err       <= 1'b0;
      end
      if (w_beat) begin
        if (r_remaining == CntWidth'(1) && r_loop) begin
          r_addr      <= r_base;
          r_remaining <= r_num;
        end else begin
          r_addr      <= r_addr + AddrWidth'(SampleBytes);
          r_remaining <= r_remaining - 1'b1;
        end
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  user_au_sample_fifo #(
    .Depth (FifoDepth),
    .Width (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (w_flush),
    .push_i  (w_push),
    .data_i  (w_push_data),
    .pop_i   (w_pop),
    .data_o  (data_o),
    .empty_o (w_empty),
    .count_o (w_count)
  );

endmodule

// File: tb/tb_user_au_obi_sample_fetcher.sv
// tb/tb_user_au_obi_sample_fetcher.sv - directed self-checking bench for the OBI sample fetcher
module tb_user_au_obi_sample_fetcher;
  import user_au_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  obi_req_t    req;
  obi_rsp_t    rsp;
  logic        start, stop, loop_cfg, ready;
  logic [31:0] base;
  logic [15:0] num;
  logic        busy, done, err, valid;
  logic [31:0] data;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem [0:255];
  logic [31:0] addr_log [$];
  logic [31:0] got [$];
  int done_cnt, resp_cnt, gnt_lat, r_lat, err_on;

  always #5 clk = ~clk;

  user_au_obi_sample_fetcher #(.FifoDepth(4), .CntWidth(16)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .obi_req_o         (req),
    .obi_rsp_i         (rsp),
    .cfg_start_i       (start),
    .cfg_stop_i        (stop),
    .cfg_loop_i        (loop_cfg),
    .cfg_base_addr_i   (base),
    .cfg_num_samples_i (num),
    .busy_o            (busy),
    .done_o            (done),
    .err_o             (err),
    .data_o            (data),
    .valid_o           (valid),
    .ready_i           (ready)
  );

  // Memory responder: decisions made on the falling edge, seen by the DUT on the next rising edge.
  initial begin : responder
    int gcnt, rcnt;
    bit pending;
    logic [31:0] paddr;
    rsp = '0; gcnt = 0; rcnt = 0; pending = 1'b0; paddr = '0;
    forever begin
      @(negedge clk);
      rsp = '0;
      if (rst) begin
        pending = 1'b0; gcnt = 0;
      end else if (pending) begin
        if (rcnt == 0) begin
          rsp.rvalid = 1'b1;
          if (resp_cnt == err_on) begin
            rsp.r.err = 1'b1; rsp.r.rdata = 32'hDEAD_BEEF;
          end else begin
            rsp.r.rdata = mem[paddr[9:2]];
          end
          resp_cnt++;
          pending = 1'b0;
        end else begin
          rcnt--;
        end
      end else if (req.req) begin
        if (gcnt >= gnt_lat) begin
          rsp.gnt = 1'b1; paddr = req.a.addr; addr_log.push_back(paddr);
          pending = 1'b1; rcnt = r_lat; gcnt = 0;
        end else begin
          gcnt++;
        end
      end else begin
        gcnt = 0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (valid && ready) got.push_back(data);
        if (done) done_cnt++;
      end
    end
  end

  task step();
    @(posedge clk); #1;
  endtask

  task clear_logs();
    addr_log.delete(); got.delete(); done_cnt = 0; resp_cnt = 0;
  endtask

  task start_pulse(input logic [31:0] b, input logic [15:0] n, input logic lp);
    base = b; num = n; loop_cfg = lp; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      step();
    end
    step();
  endtask

  task test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h want=0", data); end
    checks++; if (req.req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", req.req); end
    checks++; if (req.a.we !== 1'b0 || req.a.be !== 4'hF || req.rready !== 1'b1 || req.a.wdata !== 32'h0)
      begin errors++; $display("FAIL reset_achan got we=%b be=%h rready=%b want we=0 be=f rready=1", req.a.we, req.a.be, req.rready); end
    rst = 1'b0;
    step();
  endtask

  task test_one_shot();
    logic [31:0] exp_a [3];
    logic [31:0] exp_d [3];
    bit ok;
    exp_a = '{32'h100, 32'h104, 32'h108};
    exp_d = '{32'hA, 32'hB, 32'hC};
    ready = 1'b1; clear_logs();
    start_pulse(32'h100, 16'd3, 1'b0);
    checks++; if (busy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL oneshot_c1 got busy=%b valid=%b want 1 0", busy, valid); end
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL oneshot_c2_valid got=%b want=0", valid); end
    step();
    checks++; if (valid !== 1'b1 || data !== 32'hA) begin errors++; $display("FAIL oneshot_first got valid=%b data=%h want 1 a", valid, data); end
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL oneshot_timeout got busy=%b want 0", busy); end
    checks++; if (addr_log.size() !== 3) begin errors++; $display("FAIL oneshot_nreq got=%0d want=3", addr_log.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (i >= addr_log.size() || addr_log[i] !== exp_a[i]) begin errors++; $display("FAIL oneshot_addr%0d want=%h", i, exp_a[i]); end
      checks++; if (i >= got.size() || got[i] !== exp_d[i]) begin errors++; $display("FAIL oneshot_data%0d want=%h", i, exp_d[i]); end
    end
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL oneshot_nsamples got=%0d want=3", got.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL oneshot_done got=%0d want=1", done_cnt); end
  endtask

  task test_backpressure();
    bit ok;
    for (int i = 0; i < 8; i++) mem[128 + i] = 32'h10 + i;
    ready = 1'b0; clear_logs();
    start_pulse(32'h200, 16'd8, 1'b0);
    repeat (30) step();
    checks++; if (addr_log.size() !== 4) begin errors++; $display("FAIL bp_stalled_nreq got=%0d want=4", addr_log.size()); end
    checks++; if (valid !== 1'b1 || data !== 32'h10) begin errors++; $display("FAIL bp_head got valid=%b data=%h want 1 10", valid, data); end
    ready = 1'b1;
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got busy=%b want 0", busy); end
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL bp_nsamples got=%0d want=8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (i >= got.size() || got[i] !== 32'h10 + i) begin errors++; $display("FAIL bp_data%0d want=%h", i, 32'h10 + i); end
    end
    checks++; if (addr_log.size() !== 8 || done_cnt !== 1) begin errors++; $display("FAIL bp_totals got nreq=%0d done=%0d want 8 1", addr_log.size(), done_cnt); end
  endtask

  task test_loop();
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    exp_a = '{32'h300, 32'h304, 32'h300, 32'h304};
    exp_d = '{32'h55, 32'h66, 32'h55, 32'h66};
    mem[192] = 32'h55; mem[193] = 32'h66;
    ready = 1'b1; clear_logs();
    start_pulse(32'h300, 16'd2, 1'b1);
    repeat (20) step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (i >= addr_log.size() || addr_log[i] !== exp_a[i]) begin errors++; $display("FAIL loop_addr%0d want=%h", i, exp_a[i]); end
      checks++; if (i >= got.size() || got[i] !== exp_d[i]) begin errors++; $display("FAIL loop_data%0d want=%h", i, exp_d[i]); end
    end
    checks++; if (done_cnt !== 0 || busy !== 1'b1) begin errors++; $display("FAIL loop_running got done=%0d busy=%b want 0 1", done_cnt, busy); end
    ready = 1'b0;
    repeat (10) step();
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL loop_stop got busy=%b valid=%b want 0 0", busy, valid); end
    step();
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL loop_stop_done got=%0d want=0", done_cnt); end
    ready = 1'b1;
  endtask

  task test_error();
    bit ok;
    ready = 1'b1; clear_logs(); err_on = 1;
    start_pulse(32'h100, 16'd3, 1'b0);
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_timeout got busy=%b want 0", busy); end
    checks++; if (got.size() !== 3 || got[0] !== 32'hA || got[1] !== 32'h0 || got[2] !== 32'hC)
      begin errors++; $display("FAIL err_stream got n=%0d want a,0,c", got.size()); end
    repeat (3) step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", err); end
    err_on = -1; clear_logs();
    start_pulse(32'h100, 16'd1, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b want=0", err); end
    wait_idle(100, ok);
    checks++; if (!ok || got.size() !== 1) begin errors++; $display("FAIL err_rerun got ok=%b n=%0d want 1 1", ok, got.size()); end
  endtask

  task test_stop();
    bit ok;
    ready = 1'b1; clear_logs(); r_lat = 5;
    start_pulse(32'h100, 16'd3, 1'b0);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stopwait_pending got busy=%b want=1", busy); end
    wait_idle(40, ok);
    repeat (2) step();
    checks++; if (!ok) begin errors++; $display("FAIL stopwait_timeout got busy=%b want 0", busy); end
    checks++; if (resp_cnt !== 1 || addr_log.size() !== 1) begin errors++; $display("FAIL stopwait_bus got rsp=%0d req=%0d want 1 1", resp_cnt, addr_log.size()); end
    checks++; if (got.size() !== 0 || valid !== 1'b0 || done_cnt !== 0)
      begin errors++; $display("FAIL stopwait_drop got n=%0d valid=%b done=%0d want 0 0 0", got.size(), valid, done_cnt); end
    r_lat = 0; gnt_lat = 5; clear_logs();
    start_pulse(32'h100, 16'd3, 1'b0);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stopreq_busy got=%b want=0", busy); end
    step();
    checks++; if (addr_log.size() !== 0 || req.req !== 1'b0) begin errors++; $display("FAIL stopreq_nreq got=%0d req=%b want 0 0", addr_log.size(), req.req); end
    gnt_lat = 0;
  endtask

  task test_edge_cases();
    bit ok;
    ready = 1'b1; clear_logs();
    start_pulse(32'h100, 16'd0, 1'b0);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || req.req !== 1'b0)
      begin errors++; $display("FAIL zero_start got done=%b busy=%b req=%b want 1 0 0", done, busy, req.req); end
    step();
    checks++; if (done !== 1'b0 || addr_log.size() !== 0) begin errors++; $display("FAIL zero_after got done=%b nreq=%0d want 0 0", done, addr_log.size()); end
    ready = 1'b0; clear_logs();
    start_pulse(32'h100, 16'd2, 1'b0);
    repeat (3) step();
    start_pulse(32'h200, 16'd1, 1'b0);
    ready = 1'b1;
    wait_idle(100, ok);
    checks++; if (!ok || addr_log.size() !== 2 || addr_log[0] !== 32'h100 || addr_log[1] !== 32'h104)
      begin errors++; $display("FAIL busy_start_addrs got n=%0d want 100,104", addr_log.size()); end
    checks++; if (got.size() !== 2 || got[0] !== 32'hA || got[1] !== 32'hB || done_cnt !== 1)
      begin errors++; $display("FAIL busy_start_data got n=%0d done=%0d want 2 samples a,b 1 done", got.size(), done_cnt); end
    clear_logs();
    start_pulse(32'h103, 16'd1, 1'b0);
    wait_idle(100, ok);
    checks++; if (!ok || addr_log.size() !== 1 || addr_log[0] !== 32'h100)
      begin errors++; $display("FAIL unaligned_base got n=%0d want addr 100", addr_log.size()); end
    checks++; if (got.size() !== 1 || got[0] !== 32'hA) begin errors++; $display("FAIL unaligned_data got n=%0d want a", got.size()); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_cfg = 1'b0; ready = 1'b0;
    base = '0; num = '0;
    gnt_lat = 0; r_lat = 0; err_on = -1;
    done_cnt = 0; resp_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
    mem[64] = 32'hA; mem[65] = 32'hB; mem[66] = 32'hC;
    test_reset();
    test_one_shot();
    test_backpressure();
    test_loop();
    test_error();
    test_stop();
    test_edge_cases();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
